rtc_regfile_arbiter: RTL and testbench

- Shares the single write/read port of the RTC 16x8 time/control register file between two requesters.
- Requester 1: the time-update sequencer, which writes six BCD registers (sec..years) as a burst.
- Requester 2: the host bus interface, which does single-beat reads and writes.
- Update bursts are atomic, so the host never reads a half-updated timestamp. Arbitration between requesters alternates (round-robin) at transaction boundaries.

---
 rtl/rtc_regfile_arbiter_pkg.sv | 16 +
 rtl/rtc_regfile_arbiter_if.sv | 30 +++
 rtl/rtc_regfile_arbiter.sv | 101 ++++++++++
 tb/tb_rtc_regfile_arbiter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/rtc_regfile_arbiter_pkg.sv
// rtc_pkg: shared widths, register map and arbiter state type for the RTC register file.
package rtc_pkg;
    localparam int ADDR_W    = 4;
    localparam int DATA_W    = 8;
    localparam int REG_COUNT = 8;
    localparam logic [ADDR_W-1:0] SEC  = 4'd0;
    localparam logic [ADDR_W-1:0] MIN  = 4'd1;
    localparam logic [ADDR_W-1:0] HOUR = 4'd2;
    localparam logic [ADDR_W-1:0] DAY  = 4'd3;
    localparam logic [ADDR_W-1:0] MON  = 4'd4;
    localparam logic [ADDR_W-1:0] YEAR = 4'd5;
    localparam logic [ADDR_W-1:0] CTRL = 4'd6;
    localparam logic [ADDR_W-1:0] STAT = 4'd7;
    typedef enum logic [1:0] {IDLE, UPD_BURST, RD_WAIT1, RD_WAIT2} arb_state_t;
    typedef enum logic {PREF_UPD, PREF_HOST} pref_t;
endpackage

// File: rtl/rtc_regfile_arbiter_if.sv
// rtc_regfile_arbiter_if: update, host and register-file signals of the shared port.
interface rtc_regfile_arbiter_if;
    import rtc_pkg::*;
    logic              upd_req;
    logic [ADDR_W-1:0] upd_addr;
    logic [DATA_W-1:0] upd_data;
    logic              upd_last;
    logic              upd_gnt;
    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_gnt;
    logic [DATA_W-1:0] host_rdata;
    logic              host_rvalid;
    logic              host_err;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;
    logic              burst_active;
    modport master (
        output upd_req, upd_addr, upd_data, upd_last, host_req, host_we, host_addr, host_wdata, mem_rdata,
        input  upd_gnt, host_gnt, host_rdata, host_rvalid, host_err, mem_addr, mem_wdata, mem_we, burst_active
    );
    modport slave (
        input  upd_req, upd_addr, upd_data, upd_last, host_req, host_we, host_addr, host_wdata, mem_rdata,
        output upd_gnt, host_gnt, host_rdata, host_rvalid, host_err, mem_addr, mem_wdata, mem_we, burst_active
    );
endinterface

// File: rtl/rtc_regfile_arbiter.sv
// rtc_regfile_arbiter: round-robin sharing of the RTC register-file port between
// atomic update bursts and single-beat host accesses.
module rtc_regfile_arbiter
    import rtc_pkg::*;
#(
    parameter int BURST_MAX = 6,
    parameter int REG_COUNT = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    rtc_regfile_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(BURST_MAX + 1);

    arb_state_t        state, nxt_state;
    pref_t             pref, nxt_pref;
    logic [CNT_W-1:0]  beat_cnt, nxt_cnt;
    logic              upd_win, host_win, host_ok, wr_en, rd_en, err_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    always_comb begin
        upd_win   = 1'b0;
        host_win  = 1'b0;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        err_en    = 1'b0;
        nxt_state = state;
        nxt_pref  = pref;
        nxt_cnt   = beat_cnt;
        wr_addr   = bus.upd_addr;
        wr_data   = bus.upd_data;
        host_ok   = int'(bus.host_addr) < REG_COUNT;
        case (state)
            IDLE: begin
                upd_win  = bus.upd_req && (!bus.host_req || pref == PREF_UPD);
                host_win = bus.host_req && !upd_win;
                if (upd_win) begin
                    wr_en   = 1'b1;
                    nxt_cnt = CNT_W'(1);
                    if (bus.upd_last || BURST_MAX == 1) nxt_pref = PREF_HOST;
                    else nxt_state = UPD_BURST;
                end else if (host_win) begin
                    nxt_pref = PREF_UPD;
                    wr_addr  = bus.host_addr;
                    wr_data  = bus.host_wdata;
                    if (!host_ok) err_en = 1'b1;
                    else if (bus.host_we) wr_en = 1'b1;
                    else begin
                        rd_en     = 1'b1;
                        nxt_state = RD_WAIT1;
                    end
                end
            end
            // Host is locked out for the whole burst so it never sees a torn timestamp.
            UPD_BURST: begin
                upd_win = bus.upd_req;
                if (upd_win) begin
                    wr_en   = 1'b1;
                    nxt_cnt = beat_cnt + 1'b1;
                    if (bus.upd_last || int'(beat_cnt) + 1 >= BURST_MAX) begin
                        nxt_state = IDLE;
                        nxt_pref  = PREF_HOST;
                        nxt_cnt   = '0;
                    end
                end
            end
            RD_WAIT1: nxt_state = RD_WAIT2;
            default:  nxt_state = IDLE;
        endcase
    end

    // Grants are gated by reset so they drop the moment rst_n asserts.
    assign bus.upd_gnt      = rst_n && upd_win;
    assign bus.host_gnt     = rst_n && host_win;
    assign bus.burst_active = state == UPD_BURST;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            pref            <= PREF_UPD;
            beat_cnt        <= '0;
            bus.mem_addr    <= '0;
            bus.mem_wdata   <= '0;
            bus.mem_we      <= 1'b0;
            bus.host_rdata  <= '0;
            bus.host_rvalid <= 1'b0;
            bus.host_err    <= 1'b0;
        end else begin
            state           <= nxt_state;
            pref            <= nxt_pref;
            beat_cnt        <= nxt_cnt;
            bus.mem_we      <= wr_en;
            bus.host_err    <= err_en;
            bus.host_rvalid <= state == RD_WAIT2;
            if (wr_en || rd_en) bus.mem_addr <= wr_addr;
            if (wr_en) bus.mem_wdata <= wr_data;
            if (state == RD_WAIT2) bus.host_rdata <= bus.mem_rdata;
        end
    end
endmodule

// File: tb/tb_rtc_regfile_arbiter.sv
// tb_rtc_regfile_arbiter: directed checks of bursts, host access, alternation and reset.
module tb_rtc_regfile_arbiter;
    import rtc_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rtc_regfile_arbiter_if bus();
    rtc_regfile_arbiter #(.BURST_MAX(6), .REG_COUNT(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic [7:0] mem [16];
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= mem[bus.mem_addr];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] bd [6] = '{8'h59, 8'h59, 8'h23, 8'h31, 8'h12, 8'h99};

    initial begin
        bus.upd_req = 0; bus.upd_addr = 0; bus.upd_data = 0; bus.upd_last = 0;
        bus.host_req = 0; bus.host_we = 0; bus.host_addr = 0; bus.host_wdata = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_we", 32'(bus.mem_we), 0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 0);
        chk("rst_upd_gnt", 32'(bus.upd_gnt), 0);
        chk("rst_host_gnt", 32'(bus.host_gnt), 0);
        chk("rst_burst", 32'(bus.burst_active), 0);
        chk("rst_rvalid", 32'(bus.host_rvalid), 0);
        chk("rst_err", 32'(bus.host_err), 0);
        rst_n = 1;
        cyc();
        // six-beat update burst; host read arrives at beat 2 and must wait
        for (int i = 0; i < 6; i++) begin
            bus.upd_req = 1; bus.upd_addr = 4'(i); bus.upd_data = bd[i]; bus.upd_last = (i == 5);
            if (i == 1) begin bus.host_req = 1; bus.host_we = 0; bus.host_addr = 0; end
            #1;
            chk("burst_upd_gnt", 32'(bus.upd_gnt), 1);
            chk("burst_host_blocked", 32'(bus.host_gnt), 0);
            cyc();
            chk("burst_we", 32'(bus.mem_we), 1);
            chk("burst_addr", 32'(bus.mem_addr), i);
            chk("burst_data", 32'(bus.mem_wdata), 32'(bd[i]));
            chk("burst_active", 32'(bus.burst_active), (i < 5) ? 1 : 0);
        end
        bus.upd_req = 0; bus.upd_last = 0;
        #1;
        chk("post_burst_host_gnt", 32'(bus.host_gnt), 1);
        cyc();
        bus.host_req = 0;
        chk("rd_no_we", 32'(bus.mem_we), 0);
        chk("rd_addr", 32'(bus.mem_addr), 0);
        chk("rd_rvalid_w1", 32'(bus.host_rvalid), 0);
        cyc();
        chk("rd_rvalid_w2", 32'(bus.host_rvalid), 0);
        cyc();
        chk("rd_rvalid", 32'(bus.host_rvalid), 1);
        chk("rd_rdata", 32'(bus.host_rdata), 32'h59);
        cyc();
        chk("rd_rvalid_pulse", 32'(bus.host_rvalid), 0);
        // alternation: pref=UPD so update wins, then host wins
        bus.upd_req = 1; bus.upd_addr = 6; bus.upd_data = 8'h01; bus.upd_last = 1;
        bus.host_req = 1; bus.host_we = 0; bus.host_addr = 1;
        #1;
        chk("alt1_upd_gnt", 32'(bus.upd_gnt), 1);
        chk("alt1_host_gnt", 32'(bus.host_gnt), 0);
        cyc();
        chk("alt1_we", 32'(bus.mem_we), 1);
        chk("alt1_addr", 32'(bus.mem_addr), 6);
        bus.upd_addr = 7; bus.upd_data = 8'h02;
        #1;
        chk("alt2_host_gnt", 32'(bus.host_gnt), 1);
        chk("alt2_upd_gnt", 32'(bus.upd_gnt), 0);
        cyc();
        bus.host_req = 0;
        chk("alt2_no_we", 32'(bus.mem_we), 0);
        chk("alt2_addr", 32'(bus.mem_addr), 1);
        chk("alt2_w1_upd_gnt", 32'(bus.upd_gnt), 0);
        cyc();
        chk("alt2_w2_upd_gnt", 32'(bus.upd_gnt), 0);
        cyc();
        chk("alt2_rvalid", 32'(bus.host_rvalid), 1);
        chk("alt2_rdata", 32'(bus.host_rdata), 32'h59);
        chk("alt3_upd_gnt", 32'(bus.upd_gnt), 1);
        cyc();
        bus.upd_req = 0; bus.upd_last = 0;
        chk("alt3_we", 32'(bus.mem_we), 1);
        chk("alt3_addr", 32'(bus.mem_addr), 7);
        chk("alt3_data", 32'(bus.mem_wdata), 32'h02);
        // out-of-range host accesses and an in-range boundary write
        bus.host_req = 1; bus.host_we = 1; bus.host_addr = 9; bus.host_wdata = 8'hAA;
        #1;
        chk("err9_gnt", 32'(bus.host_gnt), 1);
        cyc();
        bus.host_req = 0;
        chk("err9_no_we", 32'(bus.mem_we), 0);
        chk("err9_err", 32'(bus.host_err), 1);
        cyc();
        chk("err9_pulse", 32'(bus.host_err), 0);
        bus.host_req = 1; bus.host_we = 0; bus.host_addr = 8;
        #1;
        chk("err8_gnt", 32'(bus.host_gnt), 1);
        cyc();
        bus.host_req = 0;
        chk("err8_err", 32'(bus.host_err), 1);
        chk("err8_no_we", 32'(bus.mem_we), 0);
        bus.host_req = 1; bus.host_we = 1; bus.host_addr = 7; bus.host_wdata = 8'h33;
        #1;
        chk("wr7_gnt", 32'(bus.host_gnt), 1);
        cyc();
        bus.host_req = 0;
        chk("wr7_we", 32'(bus.mem_we), 1);
        chk("wr7_addr", 32'(bus.mem_addr), 7);
        chk("wr7_data", 32'(bus.mem_wdata), 32'h33);
        chk("wr7_no_err", 32'(bus.host_err), 0);
        // runaway burst: no upd_last, capped at six beats, pending host read then wins
        bus.host_req = 1; bus.host_we = 0; bus.host_addr = 2;
        for (int i = 0; i < 6; i++) begin
            bus.upd_req = 1; bus.upd_addr = 4'(i); bus.upd_data = 8'(8'h10 + i); bus.upd_last = 0;
            #1;
            chk("run_upd_gnt", 32'(bus.upd_gnt), 1);
            chk("run_host_blocked", 32'(bus.host_gnt), 0);
            cyc();
            chk("run_we", 32'(bus.mem_we), 1);
            chk("run_addr", 32'(bus.mem_addr), i);
            chk("run_active", 32'(bus.burst_active), (i < 5) ? 1 : 0);
        end
        bus.upd_addr = 6; bus.upd_data = 8'h16;
        #1;
        chk("run7_upd_gnt", 32'(bus.upd_gnt), 0);
        chk("run7_host_gnt", 32'(bus.host_gnt), 1);
        cyc();
        bus.host_req = 0;
        chk("run8_no_we", 32'(bus.mem_we), 0);
        chk("run8_upd_gnt", 32'(bus.upd_gnt), 0);
        bus.upd_req = 0;
        cyc();
        cyc();
        chk("run_rvalid", 32'(bus.host_rvalid), 1);
        chk("run_rdata", 32'(bus.host_rdata), 32'h12);
        // reset asserted while beat 3 is being offered
        bus.upd_req = 1; bus.upd_addr = 0; bus.upd_data = 8'h21; bus.upd_last = 0;
        cyc();
        bus.upd_addr = 1; bus.upd_data = 8'h22;
        cyc();
        bus.upd_addr = 2; bus.upd_data = 8'h23;
        #1;
        chk("mid_upd_gnt", 32'(bus.upd_gnt), 1);
        chk("mid_we", 32'(bus.mem_we), 1);
        chk("mid_active", 32'(bus.burst_active), 1);
        rst_n = 0;
        #1;
        chk("arst_upd_gnt", 32'(bus.upd_gnt), 0);
        chk("arst_we", 32'(bus.mem_we), 0);
        chk("arst_active", 32'(bus.burst_active), 0);
        chk("arst_addr", 32'(bus.mem_addr), 0);
        cyc();
        chk("arst_we_hold", 32'(bus.mem_we), 0);
        bus.upd_req = 0;
        rst_n = 1;
        cyc();
        bus.upd_req = 1; bus.upd_addr = 4; bus.upd_data = 8'h07; bus.upd_last = 1;
        #1;
        chk("fresh_upd_gnt", 32'(bus.upd_gnt), 1);
        cyc();
        bus.upd_req = 0; bus.upd_last = 0;
        chk("fresh_we", 32'(bus.mem_we), 1);
        chk("fresh_addr", 32'(bus.mem_addr), 4);
        chk("fresh_data", 32'(bus.mem_wdata), 32'h07);
        chk("fresh_active", 32'(bus.burst_active), 0);
        bus.host_req = 1; bus.host_we = 0; bus.host_addr = 4;
        #1;
        chk("fresh_rd_gnt", 32'(bus.host_gnt), 1);
        cyc();
        bus.host_req = 0;
        cyc();
        cyc();
        chk("fresh_rvalid", 32'(bus.host_rvalid), 1);
        chk("fresh_rdata", 32'(bus.host_rdata), 32'h07);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
